// File: rtl/lm80c_pkg.sv
// rtl/lm80c_pkg.sv - shared types and widths for the LM80C RAM arbiter
package lm80c_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_WR,
    DL_WR,
    CPU_DONE
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_DL
  } grant_t;

endpackage

// File: rtl/lm80c_ram_arbiter.sv
// rtl/lm80c_ram_arbiter.sv - single-port RAM sharing between Z80 CPU and loader, CPU stalled via cpu_wait
// Optional ROM-shadow write protection of CPU writes: define LM80C_ROM_WP_EN.
module lm80c_ram_arbiter
  import lm80c_pkg::*;
#(
  parameter int                RAM_LATENCY = 2,
  parameter logic [ADDR_W-1:0] ROM_TOP     = 16'h7FFF
) (
  input  logic              sys_clock,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_mreq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              rom_en,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_rd,
  output logic              ram_wr
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              served_q, served_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic              dl_ack_q, dl_ack_d;
  logic              cpu_req;
  logic              wp_block;

`ifdef LM80C_ROM_WP_EN
  assign wp_block = rom_en & (cpu_addr <= ROM_TOP);
`else
  logic unused_wp;
  assign wp_block  = 1'b0;
  assign unused_wp = rom_en & (cpu_addr <= ROM_TOP);
`endif

  assign cpu_req = cpu_mreq & (cpu_rd | cpu_wr) & ~served_q;

  // Write data is latched at grant, so the CPU is released once the write strobe is out.
  assign cpu_wait = cpu_req & ~RESET & (state_q != CPU_DONE) & (state_q != CPU_WR);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    served_d     = cpu_mreq ? served_q : 1'b0;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_rd_d     = 1'b0;
    ram_wr_d     = 1'b0;
    dl_ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && (!dl_req || last_grant_q == GRANT_DL)) begin
          last_grant_d = GRANT_CPU;
          ram_addr_d   = cpu_addr;
          if (cpu_rd) begin
            state_d  = CPU_RD;
            ram_rd_d = 1'b1;
            cnt_d    = CNT_W'(1);
          end else begin
            state_d   = CPU_WR;
            ram_wr_d  = ~wp_block;
            ram_din_d = cpu_wdata;
          end
        end else if (dl_req) begin
          last_grant_d = GRANT_DL;
          state_d      = DL_WR;
          ram_wr_d     = 1'b1;
          dl_ack_d     = 1'b1;
          ram_addr_d   = dl_addr;
          ram_din_d    = dl_data;
        end
      end
      CPU_RD: begin
        if (cnt_q == CNT_W'(RAM_LATENCY)) begin
          cpu_rdata_d = ram_dout;
          state_d     = CPU_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CPU_WR:   state_d = CPU_DONE;
      DL_WR:    state_d = IDLE;
      CPU_DONE: begin
        state_d = IDLE;
        if (cpu_mreq) served_d = 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_CPU;
      served_q     <= 1'b0;
      cnt_q        <= '0;
      cpu_rdata_q  <= 8'hFF;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_rd_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      dl_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      served_q     <= served_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_rd_q     <= ram_rd_d;
      ram_wr_q     <= ram_wr_d;
      dl_ack_q     <= dl_ack_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dl_ack    = dl_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;

endmodule
